// File: rtl/dm_ctrl.sv
// dm_ctrl: MEM-stage word RAM with byte/half/word access and sign/zero extension; FSM clears RAM after reset.
// Response LATENCY+1 cycles after transfer; req_ready only in IDLE, no queueing. DM_TRACE_EN enables store trace.
module dm_ctrl #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    CLR  = 2'd0,
    IDLE = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         pc_q, pc_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [31:0]         mem [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_idx;
  logic [3:0]          mem_be;
  logic [31:0]         mem_wdata;
  logic                commit;

  logic [ADDR_W-1:0]   idx;
  logic [1:0]          lane;
  logic                misaligned;
  logic [31:0]         rd_word;
  logic [7:0]          ld_b;
  logic [15:0]         ld_h;
  logic [31:0]         ld_data;
  logic [3:0]          st_be;
  logic [31:0]         st_data;

  // Access decode for the latched request; only consumed on the commit edge.
  always_comb begin
    idx        = addr_q[ADDR_W+1:2];
    lane       = addr_q[1:0];
    misaligned = (size_q == 2'b11) ||
                 (size_q == 2'b01 && addr_q[0]) ||
                 (size_q == 2'b10 && addr_q[1:0] != 2'b00);
    rd_word    = mem[idx];
    ld_b       = rd_word[{lane, 3'b000} +: 8];
    ld_h       = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    ld_data    = rd_word;
    st_be      = 4'b1111;
    st_data    = wdata_q;
    case (size_q)
      2'b00: begin
        ld_data = uns_q ? {24'h0, ld_b} : {{24{ld_b[7]}}, ld_b};
        st_be   = 4'b0001 << lane;
        st_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        ld_data = uns_q ? {16'h0, ld_h} : {{16{ld_h[15]}}, ld_h};
        st_be   = addr_q[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    size_d     = size_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    pc_d       = pc_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    mem_we     = 1'b0;
    mem_idx    = clr_cnt_q;
    mem_be     = 4'b0000;
    mem_wdata  = 32'h0;
    commit     = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    if (reset) begin
      case (state_q)
        CLR: begin
          mem_we    = 1'b1;
          mem_be    = 4'b1111;
          clr_cnt_d = clr_cnt_q + 1'b1;
          if (clr_cnt_q == '1) state_d = IDLE;
        end
        IDLE: begin
          busy      = 1'b0;
          req_ready = 1'b1;
          if (req_valid) begin
            we_d    = req_we;
            size_d  = req_size;
            uns_d   = req_unsigned;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            pc_d    = req_pc;
            cnt_d   = 3'(LATENCY - 1);
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != 3'd0) begin
            cnt_d = cnt_q - 3'd1;
          end else begin
            commit  = 1'b1;
            state_d = RESP;
            err_d   = misaligned;
            rdata_d = (misaligned || we_q) ? 32'h0 : ld_data;
            if (we_q && !misaligned) begin
              mem_we    = 1'b1;
              mem_idx   = idx;
              mem_be    = st_be;
              mem_wdata = st_data;
            end
          end
        end
        RESP: begin
          resp_valid = 1'b1;
          state_d    = IDLE;
        end
        default: state_d = CLR;
      endcase
    end
  end

  assign resp_rdata = reset ? rdata_q : 32'h0;
  assign resp_err   = reset ? err_q : 1'b0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= CLR;
      clr_cnt_q <= '0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
    cnt_q   <= cnt_d;
    we_q    <= we_d;
    size_q  <= size_d;
    uns_q   <= uns_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    pc_q    <= pc_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

`ifdef DM_TRACE_EN
  logic [31:0] trace_lane_data;

  always_comb begin
    trace_lane_data = 32'h0;
    for (int b = 0; b < 4; b++) begin
      trace_lane_data[8*b +: 8] = st_be[b] ? st_data[8*b +: 8] : 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (commit && we_q && !misaligned)
      $display("%d@%h: *%h <= %h", $time, pc_q, addr_q, trace_lane_data);
  end
`else
  // PC and the wrapped address bits only feed the store trace.
  logic unused_trace;
  assign unused_trace = ^{commit, pc_q, addr_q[31:ADDR_W+2]};
`endif

endmodule

// File: tb/tb_dm_ctrl.sv
// Directed bench for dm_ctrl with ADDR_W=4, LATENCY=3: table of load/store vectors plus reset/clear sequences.
module tb_dm_ctrl;

  localparam int AW  = 4;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  always #5 clk = ~clk;

  dm_ctrl #(.ADDR_W(AW), .LATENCY(LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_pc       (req_pc),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .busy         (busy)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic we, input logic [1:0] size, input logic uns, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v = '{we, size, uns, addr, wdata, exp_rdata, exp_err};
    vq.push_back(v);
  endtask

  // One full request: wait for ready, transfer, count cycles to resp_valid, check it is a single strobe.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                        output int lat);
    int n;
    logic ready_seen;
    n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_pc       = 32'h0000_1000 + addr;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    lat        = 0;
    ready_seen = 1'b0;
    do begin
      ready_seen = ready_seen | req_ready;
      @(posedge clk); #1; lat++;
    end while (!resp_valid && lat < 50);
    rdata = resp_rdata;
    err   = resp_err;
    chk($sformatf("ready_low_while_pending@%h", addr), {31'h0, ready_seen | req_ready}, 32'h0);
    @(posedge clk); #1;
    chk($sformatf("resp_one_cycle@%h", addr), {31'h0, resp_valid}, 32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;
    logic        bad;

    reset        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    req_pc       = 32'h0;

    // Reset state and clear duration.
    #1;
    chk("reset_busy", {31'h0, busy}, 32'h1);
    chk("reset_ready", {31'h0, req_ready}, 32'h0);
    chk("reset_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("reset_rdata", resp_rdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    n   = 0;
    bad = 1'b0;
    while (busy && n < 100) begin
      bad = bad | req_ready | resp_valid;
      @(posedge clk); #1; n++;
    end
    chk("clear_cycles", n, 32'd16);
    chk("clear_ready_resp_low", {31'h0, bad}, 32'h0);

    for (int i = 0; i < 16; i++) begin
      do_req(1'b0, 2'b10, 1'b0, 32'(i * 4), 32'h0, rd, er, lat);
      chk($sformatf("cleared_word%0d", i), rd, 32'h0);
    end

    add(1, 2'b10, 0, 32'h08, 32'h12345678, 32'h00000000, 0);
    add(0, 2'b10, 0, 32'h08, 32'h0,        32'h12345678, 0);
    add(1, 2'b00, 0, 32'h09, 32'h000000AB, 32'h00000000, 0);
    add(0, 2'b10, 0, 32'h08, 32'h0,        32'h1234AB78, 0);
    add(0, 2'b00, 0, 32'h09, 32'h0,        32'hFFFFFFAB, 0);
    add(0, 2'b00, 1, 32'h09, 32'h0,        32'h000000AB, 0);
    add(1, 2'b01, 0, 32'h0A, 32'h00008001, 32'h00000000, 0);
    add(0, 2'b10, 0, 32'h08, 32'h0,        32'h8001AB78, 0);
    add(0, 2'b01, 0, 32'h0A, 32'h0,        32'hFFFF8001, 0);
    add(0, 2'b01, 1, 32'h0A, 32'h0,        32'h00008001, 0);
    add(0, 2'b01, 0, 32'h03, 32'h0,        32'h00000000, 1);
    add(1, 2'b10, 0, 32'h04, 32'hDEADBEEF, 32'h00000000, 0);
    add(1, 2'b10, 0, 32'h06, 32'h11111111, 32'h00000000, 1);
    add(0, 2'b10, 0, 32'h04, 32'h0,        32'hDEADBEEF, 0);
    add(0, 2'b11, 0, 32'h00, 32'h0,        32'h00000000, 1);
    add(1, 2'b11, 0, 32'h00, 32'hFFFFFFFF, 32'h00000000, 1);
    add(0, 2'b10, 0, 32'h00, 32'h0,        32'h00000000, 0);
    add(0, 2'b00, 0, 32'h0B, 32'h0,        32'hFFFFFF80, 0);
    add(0, 2'b00, 1, 32'h0B, 32'h0,        32'h00000080, 0);
    add(0, 2'b01, 0, 32'h08, 32'h0,        32'hFFFFAB78, 0);
    add(1, 2'b00, 0, 32'h04, 32'hFFFFFF7F, 32'h00000000, 0);
    add(0, 2'b10, 0, 32'h04, 32'h0,        32'hDEADBE7F, 0);
    add(0, 2'b10, 0, 32'h48, 32'h0,        32'h8001AB78, 0);

    foreach (vq[i]) begin
      do_req(vq[i].we, vq[i].size, vq[i].uns, vq[i].addr, vq[i].wdata, rd, er, lat);
      chk($sformatf("vec%0d rdata", i), rd, vq[i].exp_rdata);
      chk($sformatf("vec%0d err", i), {31'h0, er}, {31'h0, vq[i].exp_err});
      chk($sformatf("vec%0d latency", i), lat, LAT);
    end

    // req_valid held through WAIT/RESP of a load must not start a second request.
    n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h04;
    @(posedge clk); #1;
    req_we = 1'b1; req_wdata = 32'h55555555;
    n = 0;
    while (!resp_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    req_valid = 1'b0;
    chk("held_valid_load_rdata", resp_rdata, 32'hDEADBE7F);
    do_req(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, rd, er, lat);
    chk("held_valid_no_store", rd, 32'hDEADBE7F);

    // Reset asserted in WAIT of a store and held across its commit edge.
    n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h00; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    bad   = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bad = bad | resp_valid;
      @(posedge clk); #1;
    end
    chk("abort_busy", {31'h0, busy}, 32'h1);
    chk("abort_ready", {31'h0, req_ready}, 32'h0);
    reset = 1'b1;
    n = 0;
    while (busy && n < 100) begin
      bad = bad | resp_valid;
      @(posedge clk); #1; n++;
    end
    chk("abort_no_resp", {31'h0, bad}, 32'h0);
    chk("abort_clear_cycles", n, 32'd16);
    do_req(1'b0, 2'b10, 1'b0, 32'h00, 32'h0, rd, er, lat);
    chk("abort_word0", rd, 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, rd, er, lat);
    chk("abort_word8_cleared", rd, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
